// File: rtl/backtrack_pkg.sv
// Shared types for the backtrack unit: FSM states, trace-table entry layout, widths.
// Latency: n/a (types only).
// Backpressure: n/a.
package backtrack_pkg;

    localparam int MAX_VARS = 64;
    localparam int VAR_W    = $clog2(MAX_VARS);
    localparam int CNT_W    = $clog2(MAX_VARS) + 1;

    localparam logic TYPE_DECIDE = 1'b0;
    localparam logic TYPE_FORCED = 1'b1;

    typedef enum logic [2:0] {
        BT_IDLE   = 3'd0,
        BT_POP    = 3'd1,
        BT_REPUSH = 3'd2,
        BT_FIN    = 3'd3,
        BT_NOSAT  = 3'd4
    } bt_state_e;

    typedef struct packed {
        logic             etype;
        logic             val;
        logic [VAR_W-1:0] vidx;
    } trace_entry_t;

    // A decision becomes a forced entry carrying the opposite value.
    function automatic trace_entry_t flip_entry(input trace_entry_t e);
        trace_entry_t r;
        r       = e;
        r.etype = TYPE_FORCED;
        r.val   = ~e.val;
        return r;
    endfunction

endpackage

// File: rtl/backtrack_unit_if.sv
// Bundle between backtrack unit, conflict detector, trace table and assignment store.
// Latency: n/a. Backpressure: trace_full stalls the re-push.
// BACKTRACK_STATS_EN adds stat_pops / stat_backtracks.
interface backtrack_unit_if;
    import backtrack_pkg::*;

    logic             start;
    logic             trace_empty;
    logic             trace_full;
    logic             trace_type;
    logic             trace_val;
    logic [VAR_W-1:0] trace_var;
    logic             trace_pop;
    logic             trace_push;
    logic             trace_push_type;
    logic             trace_push_val;
    logic [VAR_W-1:0] trace_push_var;
    logic             unassign_en;
    logic [VAR_W-1:0] unassign_var;
    logic             assign_en;
    logic [VAR_W-1:0] assign_var;
    logic             assign_val;
    logic             busy;
    logic             done;
    logic             unsat;
`ifdef BACKTRACK_STATS_EN
    logic [CNT_W-1:0] stat_pops;
    logic [31:0]      stat_backtracks;
`endif

    modport master (
        input  start, trace_empty, trace_full, trace_type, trace_val, trace_var,
        output trace_pop, trace_push, trace_push_type, trace_push_val, trace_push_var,
        output unassign_en, unassign_var, assign_en, assign_var, assign_val,
        output busy, done, unsat
`ifdef BACKTRACK_STATS_EN
        , output stat_pops, stat_backtracks
`endif
    );

    modport slave (
        output start, trace_empty, trace_full, trace_type, trace_val, trace_var,
        input  trace_pop, trace_push, trace_push_type, trace_push_val, trace_push_var,
        input  unassign_en, unassign_var, assign_en, assign_var, assign_val,
        input  busy, done, unsat
`ifdef BACKTRACK_STATS_EN
        , input stat_pops, stat_backtracks
`endif
    );

endinterface

// File: rtl/backtrack_unit.sv
// Pops the trace table down to the latest decision, unassigning as it goes, then re-pushes it flipped.
// Latency: done k+3 cycles after start (k forced entries above the decision); unsat 2 cycles after start on empty.
// Backpressure: one pop per cycle; re-push holds while trace_full. Optional stats under BACKTRACK_STATS_EN.
module backtrack_unit
    import backtrack_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    backtrack_unit_if.master  bt
);

    bt_state_e    state_q, state_d;
    trace_entry_t saved_q, saved_d;
    trace_entry_t push_ent;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= BT_IDLE;
            saved_q <= '0;
        end else begin
            state_q <= state_d;
            saved_q <= saved_d;
        end
    end

    always_comb begin
        state_d = state_q;
        saved_d = saved_q;
        case (state_q)
            BT_IDLE: begin
                if (bt.start) state_d = BT_POP;
            end
            BT_POP: begin
                if (bt.trace_empty) begin
                    state_d = BT_NOSAT;
                end else if (bt.trace_type == TYPE_DECIDE) begin
                    saved_d = '{etype: TYPE_DECIDE, val: bt.trace_val, vidx: bt.trace_var};
                    state_d = BT_REPUSH;
                end
            end
            BT_REPUSH: begin
                if (!bt.trace_full) state_d = BT_FIN;
            end
            BT_FIN:   state_d = BT_IDLE;
            BT_NOSAT: state_d = BT_IDLE;
            default:  state_d = BT_IDLE;
        endcase
    end

    assign push_ent = flip_entry(saved_q);

    always_comb begin
        bt.trace_pop       = 1'b0;
        bt.trace_push      = 1'b0;
        bt.trace_push_type = 1'b0;
        bt.trace_push_val  = 1'b0;
        bt.trace_push_var  = '0;
        bt.unassign_en     = 1'b0;
        bt.unassign_var    = '0;
        bt.assign_en       = 1'b0;
        bt.assign_var      = '0;
        bt.assign_val      = 1'b0;
        bt.done            = 1'b0;
        bt.unsat           = 1'b0;
        bt.busy            = (state_q != BT_IDLE);
        case (state_q)
            BT_POP: begin
                if (!bt.trace_empty) begin
                    bt.trace_pop    = 1'b1;
                    bt.unassign_en  = 1'b1;
                    bt.unassign_var = bt.trace_var;
                end
            end
            BT_REPUSH: begin
                // Table full here means a misbehaving table; wait rather than drop the entry.
                if (!bt.trace_full) begin
                    bt.trace_push      = 1'b1;
                    bt.trace_push_type = push_ent.etype;
                    bt.trace_push_val  = push_ent.val;
                    bt.trace_push_var  = push_ent.vidx;
                    bt.assign_en       = 1'b1;
                    bt.assign_var      = push_ent.vidx;
                    bt.assign_val      = push_ent.val;
                end
            end
            BT_FIN:   bt.done  = 1'b1;
            BT_NOSAT: bt.unsat = 1'b1;
            default: ;
        endcase
    end

`ifdef BACKTRACK_STATS_EN
    logic [CNT_W-1:0] pop_cnt_q, pop_cnt_d;
    logic [CNT_W-1:0] stat_pops_q, stat_pops_d;
    logic [31:0]      stat_bt_q, stat_bt_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            pop_cnt_q   <= '0;
            stat_pops_q <= '0;
            stat_bt_q   <= '0;
        end else begin
            pop_cnt_q   <= pop_cnt_d;
            stat_pops_q <= stat_pops_d;
            stat_bt_q   <= stat_bt_d;
        end
    end

    always_comb begin
        pop_cnt_d   = pop_cnt_q;
        stat_pops_d = stat_pops_q;
        stat_bt_d   = stat_bt_q;
        if (state_q == BT_IDLE && bt.start) begin
            pop_cnt_d = '0;
        end else if (bt.trace_pop) begin
            pop_cnt_d = pop_cnt_q + CNT_W'(1);
        end
        if (state_q == BT_FIN || state_q == BT_NOSAT) begin
            stat_pops_d = pop_cnt_q;
        end
        if (state_q == BT_FIN && stat_bt_q != '1) begin
            stat_bt_d = stat_bt_q + 32'd1;
        end
    end

    assign bt.stat_pops       = stat_pops_q;
    assign bt.stat_backtracks = stat_bt_q;
`endif

endmodule

// File: tb/tb_backtrack_unit.sv
// Scoreboard bench: a stack model of the trace table feeds the unit; the monitor checks each active cycle.
module tb_backtrack_unit;
    import backtrack_pkg::*;

    typedef struct packed {
        logic [7:0]       rel;
        logic             busy;
        logic             pop;
        logic             uen;
        logic [VAR_W-1:0] uvar;
        logic             push;
        logic             ptype;
        logic             pval;
        logic [VAR_W-1:0] pvar;
        logic             aen;
        logic [VAR_W-1:0] avar;
        logic             aval;
        logic             done;
        logic             unsat;
    } ev_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    backtrack_unit_if bif ();

    backtrack_unit dut (
        .clock (clock),
        .reset (reset),
        .bt    (bif.master)
    );

    // Trace-table stack model, bottom at index 0.
    trace_entry_t tbl [0:7];
    trace_entry_t ld_ent [0:3];
    trace_entry_t top_ent;
    int           sp = 0;
    int           ld_n = 0;
    logic         ld_en = 1'b0;

    always @(posedge clock) begin
        if (ld_en) begin
            for (int i = 0; i < 4; i++) tbl[i] <= ld_ent[i];
            sp <= ld_n;
        end else if (bif.trace_pop && sp > 0) begin
            sp <= sp - 1;
        end else if (bif.trace_push && sp < 8) begin
            tbl[sp] <= '{etype: bif.trace_push_type, val: bif.trace_push_val, vidx: bif.trace_push_var};
            sp <= sp + 1;
        end
    end

    assign top_ent         = (sp > 0) ? tbl[sp-1] : '0;
    assign bif.trace_empty = (sp == 0);
    assign bif.trace_full  = (sp >= 8);
    assign bif.trace_type  = top_ent.etype;
    assign bif.trace_val   = top_ent.val;
    assign bif.trace_var   = top_ent.vidx;

    int   cyc = 0;
    int   start_cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    ev_t  exp_q [$];
    ev_t  act;
    ev_t  exp_e;
    int   checks = 0;
    int   errors = 0;
    logic mon_en = 1'b0;
    logic q_chk = 1'b0;
    logic fin_chk = 1'b0;
    int   exp_sp = 0;
    int   exp_sb = 0;

    always @(negedge clock) begin
        if (mon_en) begin
            act.rel   = 8'(cyc - start_cyc);
            act.busy  = bif.busy;
            act.pop   = bif.trace_pop;
            act.uen   = bif.unassign_en;
            act.uvar  = bif.unassign_var;
            act.push  = bif.trace_push;
            act.ptype = bif.trace_push_type;
            act.pval  = bif.trace_push_val;
            act.pvar  = bif.trace_push_var;
            act.aen   = bif.assign_en;
            act.avar  = bif.assign_var;
            act.aval  = bif.assign_val;
            act.done  = bif.done;
            act.unsat = bif.unsat;
            if (act.busy || act.pop || act.uen || act.push || act.aen || act.done || act.unsat) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL evt_unexpected got=%h want=none", act);
                end else begin
                    exp_e = exp_q.pop_front();
                    if (act !== exp_e) begin
                        errors++;
                        $display("FAIL evt rel=%0d got=%h want=%h", act.rel, act, exp_e);
                    end
                end
                checks++;
                if (act.pop && act.push) begin
                    errors++;
                    $display("FAIL pop_push_overlap got=11 want=not both");
                end
            end
            if (q_chk) begin
                checks++;
                if ({act.pop, act.push, act.ptype, act.pval, act.pvar, act.uen, act.uvar,
                     act.aen, act.avar, act.aval, act.busy, act.done, act.unsat} !== '0) begin
                    errors++;
                    $display("FAIL quiet got=%h want=0", act);
                end
`ifdef BACKTRACK_STATS_EN
                checks++;
                if (int'(bif.stat_pops) != exp_sp || int'(bif.stat_backtracks) != exp_sb) begin
                    errors++;
                    $display("FAIL stats got=%0d/%0d want=%0d/%0d",
                             bif.stat_pops, bif.stat_backtracks, exp_sp, exp_sb);
                end
`endif
            end
            if (fin_chk) begin
                checks++;
                if (exp_q.size() != 0) begin
                    errors++;
                    $display("FAIL leftover_events got=%0d want=0", exp_q.size());
                end
            end
        end
    end

    function automatic trace_entry_t mk(input logic t, input logic v, input int x);
        return '{etype: t, val: v, vidx: VAR_W'(x)};
    endfunction

    function automatic ev_t ev_base(input int rel);
        ev_t e;
        e      = '0;
        e.rel  = 8'(rel);
        e.busy = 1'b1;
        return e;
    endfunction

    function automatic ev_t ev_pop(input int rel, input int x);
        ev_t e;
        e      = ev_base(rel);
        e.pop  = 1'b1;
        e.uen  = 1'b1;
        e.uvar = VAR_W'(x);
        return e;
    endfunction

    function automatic ev_t ev_push(input int rel, input int x, input logic v);
        ev_t e;
        e       = ev_base(rel);
        e.push  = 1'b1;
        e.ptype = 1'b1;
        e.pval  = v;
        e.pvar  = VAR_W'(x);
        e.aen   = 1'b1;
        e.avar  = VAR_W'(x);
        e.aval  = v;
        return e;
    endfunction

    function automatic ev_t ev_done(input int rel);
        ev_t e;
        e      = ev_base(rel);
        e.done = 1'b1;
        return e;
    endfunction

    function automatic ev_t ev_unsat(input int rel);
        ev_t e;
        e       = ev_base(rel);
        e.unsat = 1'b1;
        return e;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load(input int n, input trace_entry_t e0, input trace_entry_t e1,
                        input trace_entry_t e2);
        ld_n      = n;
        ld_ent[0] = e0;
        ld_ent[1] = e1;
        ld_ent[2] = e2;
        ld_ent[3] = '0;
        ld_en     = 1'b1;
        tick();
        ld_en     = 1'b0;
    endtask

    task automatic quiet(input int sp_want, input int sb_want);
        exp_sp = sp_want;
        exp_sb = sb_want;
        q_chk  = 1'b1;
        tick();
        q_chk  = 1'b0;
    endtask

    task automatic fire();
        bif.start = 1'b1;
        start_cyc = cyc;
        tick();
        bif.start = 1'b0;
    endtask

    task automatic expect_test1();
        exp_q.push_back(ev_pop(1, 7));
        exp_q.push_back(ev_pop(2, 5));
        exp_q.push_back(ev_pop(3, 3));
        exp_q.push_back(ev_push(4, 3, 1'b0));
        exp_q.push_back(ev_done(5));
    endtask

    initial begin
        bif.start = 1'b0;
        tick();
        tick();
        mon_en = 1'b1;
        quiet(0, 0);
        reset = 1'b0;
        quiet(0, 0);

        // Two forced entries above decision x3=1.
        load(3, mk(TYPE_DECIDE, 1'b1, 3), mk(TYPE_FORCED, 1'b0, 5), mk(TYPE_FORCED, 1'b1, 7));
        expect_test1();
        fire();
        repeat (6) tick();
        quiet(3, 1);

        // Lone decision x2=0.
        load(1, mk(TYPE_DECIDE, 1'b0, 2), '0, '0);
        exp_q.push_back(ev_pop(1, 2));
        exp_q.push_back(ev_push(2, 2, 1'b1));
        exp_q.push_back(ev_done(3));
        fire();
        repeat (4) tick();
        quiet(1, 2);

        // Only forced entries: drains then unsat.
        load(2, mk(TYPE_FORCED, 1'b1, 1), mk(TYPE_FORCED, 1'b0, 4), '0);
        exp_q.push_back(ev_pop(1, 4));
        exp_q.push_back(ev_pop(2, 1));
        exp_q.push_back(ev_base(3));
        exp_q.push_back(ev_unsat(4));
        fire();
        repeat (5) tick();
        quiet(2, 2);

        // Empty table at start.
        load(0, '0, '0, '0);
        exp_q.push_back(ev_base(1));
        exp_q.push_back(ev_unsat(2));
        fire();
        repeat (3) tick();
        quiet(0, 2);

        // Reset in POP right after the first pop.
        load(3, mk(TYPE_DECIDE, 1'b1, 3), mk(TYPE_FORCED, 1'b0, 5), mk(TYPE_FORCED, 1'b1, 7));
        exp_q.push_back(ev_pop(1, 7));
        fire();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        quiet(0, 0);
        repeat (2) tick();
        quiet(0, 0);

        // Same as the first run, with a stray start while busy.
        load(3, mk(TYPE_DECIDE, 1'b1, 3), mk(TYPE_FORCED, 1'b0, 5), mk(TYPE_FORCED, 1'b1, 7));
        expect_test1();
        fire();
        tick();
        bif.start = 1'b1;
        tick();
        bif.start = 1'b0;
        repeat (5) tick();
        quiet(3, 1);

        fin_chk = 1'b1;
        tick();
        fin_chk = 1'b0;
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
